// File: rtl/ravenna_spi_pkg.sv
// Shared state encodings and config register bit positions for the Ravenna SPI master.
package ravenna_spi_pkg;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_SETUP = 2'd1;
  localparam spi_state_t ST_SHIFT = 2'd2;
  localparam spi_state_t ST_HOLD  = 2'd3;

  localparam int unsigned CFG_W    = 12;
  localparam int unsigned CFG_CPOL = 8;
  localparam int unsigned CFG_CPHA = 9;
  localparam int unsigned CFG_HOLD = 10;
  localparam int unsigned CFG_EN   = 11;
  localparam int unsigned BUSY_BIT = 31;

endpackage

// File: rtl/ravenna_spi_clkgen.sv
// Half-period tick generator: one tick every prescale+1 clk cycles while running.
module ravenna_spi_clkgen #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = run && (cnt == prescale);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/ravenna_spi_master.sv
// Memory-mapped SPI master: one full-duplex byte per data write, optional CSB hold for bursts.
module ravenna_spi_master
  import ravenna_spi_pkg::*;
#(
  parameter int PRESCALE_W = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              reg_cfg_we,
  input  logic [31:0]       reg_cfg_di,
  output logic [31:0]       reg_cfg_do,
  input  logic              reg_dat_we,
  input  logic              reg_dat_re,
  input  logic [DATA_W-1:0] reg_dat_di,
  output logic [DATA_W-1:0] reg_dat_do,
  output logic              reg_dat_wait,
  output logic              spi_csb,
  output logic              spi_sck,
  output logic              spi_sdo,
  input  logic              spi_sdi,
  output logic              irq_done
);

  localparam int unsigned BCW = $clog2(2 * DATA_W);

  spi_state_t            state;
  logic [CFG_W-1:0]      cfg;
  logic [CFG_W-1:0]      cfg_eff;
  logic [DATA_W-1:0]     tx_sr;
  logic [DATA_W-1:0]     rx_sr;
  logic [DATA_W-1:0]     dat_q;
  logic [BCW-1:0]        bit_cnt;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  cpha_q;
  logic                  sck_q;
  logic                  csb_q;
  logic                  sdo_q;
  logic                  irq_q;
  logic                  busy;
  logic                  start;
  logic                  abort;
  logic                  tick;
  logic                  lead;
  logic                  unused_cfg_bits;

  assign unused_cfg_bits = ^reg_cfg_di[31:CFG_W];

  // A cfg write in the same cycle as a start takes effect for that transfer.
  assign cfg_eff = reg_cfg_we ? reg_cfg_di[CFG_W-1:0] : cfg;
  assign busy    = (state != ST_IDLE);
  assign start   = (state == ST_IDLE) && reg_dat_we && cfg_eff[CFG_EN];
  assign abort   = busy && !cfg_eff[CFG_EN];
  assign lead    = ~bit_cnt[0];

  ravenna_spi_clkgen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_clkgen (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (start),
    .run      (busy),
    .prescale (presc_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cfg     <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      dat_q   <= '0;
      bit_cnt <= '0;
      presc_q <= '0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      sdo_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (reg_cfg_we) cfg <= reg_cfg_di[CFG_W-1:0];
      irq_q <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        csb_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_SETUP;
              csb_q   <= 1'b0;
              tx_sr   <= reg_dat_di;
              rx_sr   <= '0;
              presc_q <= cfg_eff[PRESCALE_W-1:0];
              cpha_q  <= cfg_eff[CFG_CPHA];
              sck_q   <= cfg_eff[CFG_CPOL];
              if (!cfg_eff[CFG_CPHA]) sdo_q <= reg_dat_di[DATA_W-1];
            end else if (!cfg[CFG_HOLD] || !cfg[CFG_EN]) begin
              csb_q <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (tick) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              sck_q   <= ~sck_q;
              bit_cnt <= bit_cnt + BCW'(1);
              // Sample edge is leading for cpha=0 and trailing for cpha=1.
              if (lead ^ cpha_q) begin
                rx_sr <= {rx_sr[DATA_W-2:0], spi_sdi};
              end else begin
                sdo_q <= cpha_q ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
              end
              if (bit_cnt == BCW'(2 * DATA_W - 1)) state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (tick) begin
              state <= ST_IDLE;
              dat_q <= rx_sr;
              irq_q <= 1'b1;
              if (!cfg[CFG_HOLD]) csb_q <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    reg_cfg_do           = '0;
    reg_cfg_do[CFG_W-1:0] = cfg;
    reg_cfg_do[BUSY_BIT] = busy;
  end

  assign spi_sck      = busy ? sck_q : cfg[CFG_CPOL];
  assign spi_csb      = csb_q;
  assign spi_sdo      = sdo_q;
  assign reg_dat_do   = dat_q;
  assign irq_done     = irq_q;
  assign reg_dat_wait = busy && (reg_dat_we || reg_dat_re);

endmodule
